// File: rtl/sipo_frame_deserializer_if.sv
// Word-side and bit-side signals of the frame deserializer bundled as one port.
// slave = the deserializer itself, master = the serial front end / consumer side.
interface sipo_frame_deserializer_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: a word transfers on any rising clk edge where out_valid and
    // out_ready are both 1; out_valid never drops without a transfer or a reset.
    logic             serial_in;
    logic             bit_valid;
    logic             frame_start;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity_err;
    logic             overrun;
    logic             clear_overrun;
    logic             busy;
    logic [CW-1:0]    bit_count;
    logic             state_dbg;

    modport slave (
        input  serial_in, bit_valid, frame_start, out_ready, clear_overrun,
        output out_data, out_valid, out_parity_err, overrun, busy, bit_count, state_dbg
    );

    modport master (
        output serial_in, bit_valid, frame_start, out_ready, clear_overrun,
        input  out_data, out_valid, out_parity_err, overrun, busy, bit_count, state_dbg
    );
endinterface

// File: rtl/sipo_frame_deserializer.sv
// Serial-to-parallel frame receiver: WIDTH data bits plus optional parity bit,
// one-word holding register on a valid/ready output with sticky overrun.
module sipo_frame_deserializer #(
    parameter int WIDTH         = 8,
    parameter int MSB_FIRST     = 1,
    parameter int PARITY_ENABLE = 1,
    parameter int PARITY_TYPE   = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    sipo_frame_deserializer_if.slave              bus
);
    localparam int       CW     = $clog2(WIDTH + 1);
    localparam logic     PAR_ODD = (PARITY_TYPE != 0);

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt, shifted, word;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             complete, err, accept;

    always_comb begin
        if (MSB_FIRST != 0) shifted = {sr[WIDTH-2:0], bus.serial_in};
        else                shifted = {bus.serial_in, sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_DATA;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        complete  = 1'b0;
        word      = sr;
        err       = 1'b0;
        // A restart wins over everything; a frame finishing in that cycle is lost.
        if (bus.frame_start) begin
            state_nxt = ST_DATA;
            if (bus.bit_valid) begin
                sr_nxt  = shifted;
                cnt_nxt = CW'(1);
            end else begin
                cnt_nxt = '0;
            end
        end else if (bus.bit_valid) begin
            if (state == ST_DATA) begin
                sr_nxt = shifted;
                if (cnt == CW'(WIDTH - 1)) begin
                    if (PARITY_ENABLE != 0) begin
                        state_nxt = ST_PARITY;
                        cnt_nxt   = CW'(WIDTH);
                    end else begin
                        complete = 1'b1;
                        word     = shifted;
                        cnt_nxt  = '0;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end else begin
                complete  = 1'b1;
                err       = (bus.serial_in != ((^sr) ^ PAR_ODD));
                cnt_nxt   = '0;
                state_nxt = ST_DATA;
            end
        end
    end

    // The holding register can take a new word if empty or being drained now.
    assign accept = !bus.out_valid || bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_data       <= '0;
            bus.out_valid      <= 1'b0;
            bus.out_parity_err <= 1'b0;
            bus.overrun        <= 1'b0;
        end else begin
            if (complete && accept) begin
                bus.out_data       <= word;
                bus.out_parity_err <= err;
                bus.out_valid      <= 1'b1;
            end else if (bus.out_valid && bus.out_ready && !complete) begin
                bus.out_valid <= 1'b0;
            end
            if (complete && !accept) bus.overrun <= 1'b1;
            else if (bus.clear_overrun) bus.overrun <= 1'b0;
        end
    end

    assign bus.busy      = (cnt != '0) || (state == ST_PARITY);
    assign bus.bit_count = cnt;
    assign bus.state_dbg = state;
endmodule
